multdiv_sequencer: RTL and testbench

//  Multi-cycle signed 32-bit multiply/divide unit for the processor's execute stage.

---
 rtl/multdiv_sequencer_if.sv | 24 ++
 rtl/multdiv_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_if.sv
// Operand/control and result bundle between the execute stage and the multiply/divide sequencer.
interface multdiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    // Pipeline side: issues operands and start pulses, consumes results
    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    // Sequencer side
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply / restoring divide built around a single shared add/sub unit.
// Every arithmetic step (operand abs, iterations, result sign fix) goes through that one adder.
module multdiv_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter bit          MULT_PRIORITY = 1'b1
) (
    input logic                clock,
    input logic                reset,
    multdiv_sequencer_if.slave bus_io
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic             mul_q, mul_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] a_q, a_d;      // |A|: multiplicand or dividend
    logic [WIDTH-1:0] b_q, b_d;      // raw B until PREP, then |B|
    logic [WIDTH-1:0] hi_q, hi_d;    // product high half / remainder
    logic [WIDTH-1:0] lo_q, lo_d;    // multiplier shifting into product low half / quotient
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic             start_c;
    logic             mul_sel_c;
    logic [WIDTH-1:0] add_a_c;
    logic [WIDTH-1:0] add_b_c;
    logic             add_sub_c;
    logic [WIDTH:0]   add_full_c;
    logic [WIDTH-1:0] add_sum_c;
    logic [WIDTH:0]   mul_ext_c;
    logic             mul_ovf_c;
    logic             div_ovf_c;

    // Any ctrl pulse (re)starts an operation; priority picks the op when both are high
    assign start_c   = bus_io.ctrl_MULT | bus_io.ctrl_DIV;
    assign mul_sel_c = MULT_PRIORITY ? bus_io.ctrl_MULT : (bus_io.ctrl_MULT & ~bus_io.ctrl_DIV);

    // The single add/sub unit: subtract is a + ~b + 1, carry out kept as the top bit
    assign add_full_c = {1'b0, add_a_c} + {1'b0, add_b_c ^ {WIDTH{add_sub_c}}} + (WIDTH+1)'(add_sub_c);
    assign add_sum_c  = add_full_c[WIDTH-1:0];

    // Multiply step partial sum: add multiplicand only when the multiplier LSB is set
    assign mul_ext_c = lo_q[0] ? add_full_c : {1'b0, hi_q};

    // Magnitude product fits signed 32 unless it exceeds 2^31-1; exactly 2^31 is fine when negative
    assign mul_ovf_c = (hi_q != '0) ||
                       (lo_q[WIDTH-1] && !(sign_q && (lo_q[WIDTH-2:0] == '0)));
    // Only -2^31 / -1 yields a positive quotient magnitude of 2^31
    assign div_ovf_c = !sign_q && lo_q[WIDTH-1];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start pulse overrides whatever is in flight
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = S_PREP;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_PREP: begin
                    if (!mul_q && (b_q == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = mul_q ? S_MUL : S_DIV;
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Add/sub operand steering for the current step
    always_comb begin
        add_a_c   = '0;
        add_b_c   = '0;
        add_sub_c = 1'b0;
        if (start_c) begin
            add_b_c   = bus_io.data_operandA;
            add_sub_c = 1'b1;
        end else begin
            case (state_q)
                S_PREP: begin
                    add_b_c   = b_q;
                    add_sub_c = 1'b1;
                end
                S_MUL: begin
                    add_a_c = hi_q;
                    add_b_c = a_q;
                end
                S_DIV: begin
                    add_a_c   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                    add_b_c   = b_q;
                    add_sub_c = 1'b1;
                end
                S_FIX: begin
                    add_b_c   = lo_q;
                    add_sub_c = 1'b1;
                end
                default: begin
                    add_a_c   = '0;
                    add_b_c   = '0;
                    add_sub_c = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        mul_d  = mul_q;
        sign_d = sign_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        exc_d  = exc_q;
        rdy_d  = 1'b0;
        if (start_c) begin
            mul_d  = mul_sel_c;
            sign_d = bus_io.data_operandA[WIDTH-1] ^ bus_io.data_operandB[WIDTH-1];
            a_d    = bus_io.data_operandA[WIDTH-1] ? add_sum_c : bus_io.data_operandA;
            b_d    = bus_io.data_operandB;
            cnt_d  = '0;
        end else begin
            case (state_q)
                S_PREP: begin
                    b_d   = b_q[WIDTH-1] ? add_sum_c : b_q;
                    hi_d  = '0;
                    lo_d  = mul_q ? (b_q[WIDTH-1] ? add_sum_c : b_q) : a_q;
                    cnt_d = '0;
                    if (!mul_q && (b_q == '0)) begin
                        res_d = '0;
                        exc_d = 1'b1;
                        rdy_d = 1'b1;
                    end
                end
                S_MUL: begin
                    {hi_d, lo_d} = {mul_ext_c, lo_q[WIDTH-1:1]};
                    cnt_d        = cnt_q + CNT_W'(1);
                end
                S_DIV: begin
                    hi_d  = add_sum_c[WIDTH-1] ? add_a_c : add_sum_c;
                    lo_d  = {lo_q[WIDTH-2:0], ~add_sum_c[WIDTH-1]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                S_FIX: begin
                    res_d = sign_q ? add_sum_c : lo_q;
                    exc_d = mul_q ? mul_ovf_c : div_ovf_c;
                    rdy_d = 1'b1;
                end
                default: begin
                    rdy_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            mul_q  <= 1'b0;
            sign_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            exc_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            mul_q  <= mul_d;
            sign_q <= sign_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            exc_q  <= exc_d;
            rdy_q  <= rdy_d;
        end
    end

    assign bus_io.data_result    = res_q;
    assign bus_io.data_exception = exc_q;
    assign bus_io.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for the multiply/divide sequencer: fixed vector table, multi-cycle corner sequences,
// and random operations against an arithmetic reference model.
module tb_multdiv_sequencer;

    logic clock;
    logic reset;

    multdiv_sequencer_if #(.WIDTH(32)) bus ();

    multdiv_sequencer #(.WIDTH(32), .MULT_PRIORITY(1'b1)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    typedef struct {
        logic        cm;
        logic        cd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
        int          lat;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference: exact signed arithmetic; latency counted in cycles with ctrl in cycle 0
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input bit mul,
                                      output logic [31:0] r, output bit e, output int lat);
        longint p;
        int     sa;
        int     sb;
        sa  = $signed(a);
        sb  = $signed(b);
        lat = 35;
        if (mul) begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r   = 32'd0;
            e   = 1'b1;
            lat = 2;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'(sa / sb);
            e = 1'b0;
        end
    endfunction

    // Issue one op, wait for RDY, check latency, result, exception and single-cycle RDY
    task automatic run_op(input logic cm, input logic cd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input int elat, input string nm);
        int e;
        int got_lat;
        logic [31:0] gr;
        logic        ge;
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = cm;
        bus.ctrl_DIV      = cd;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        e = 0;
        while (!bus.data_resultRDY && e < 60) begin
            @(posedge clock);
            #1;
            e++;
        end
        got_lat = bus.data_resultRDY ? e + 1 : -1;
        gr = bus.data_result;
        ge = bus.data_exception;
        chk({nm, " latency"}, 32'(got_lat), 32'(elat));
        chk({nm, " result"}, gr, er);
        chk({nm, " exception"}, {31'd0, ge}, {31'd0, ee});
        @(posedge clock);
        #1;
        chk({nm, " rdy_single"}, {31'd0, bus.data_resultRDY}, 32'd0);
    endtask

    vec_t        vt[$];
    logic [31:0] corner[8];

    initial begin
        int          n_rdy;
        int          first_e;
        int          second_e;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rr;
        bit          re;
        bit          rm;
        bit          rboth;
        int          rl;

        corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000,
                   32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0001_0000};

        vt.push_back('{1'b1, 1'b0, 32'd6,          32'd7,          32'd42,          1'b0, 35});
        vt.push_back('{1'b1, 1'b0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,   1'b0, 35});
        vt.push_back('{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000,  32'd0,           1'b1, 35});
        vt.push_back('{1'b1, 1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000,   1'b0, 35});
        vt.push_back('{1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,   1'b0, 35});
        vt.push_back('{1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,   1'b0, 35});
        vt.push_back('{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1'b1, 35});
        vt.push_back('{1'b0, 1'b1, 32'd5,          32'd0,          32'd0,           1'b1, 2});
        vt.push_back('{1'b0, 1'b1, 32'd9,          32'd3,          32'd3,           1'b0, 35});
        vt.push_back('{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1'b1, 35});
        vt.push_back('{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,           1'b0, 35});
        vt.push_back('{1'b0, 1'b1, 32'h8000_0000,  32'h8000_0000,  32'd1,           1'b0, 35});
        vt.push_back('{1'b0, 1'b1, 32'd7,          32'h8000_0000,  32'd0,           1'b0, 35});
        vt.push_back('{1'b1, 1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,           1'b1, 35});
        vt.push_back('{1'b1, 1'b0, 32'd0,          32'hFFFF_FFFB,  32'd0,           1'b0, 35});
        vt.push_back('{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   1'b0, 35});
        vt.push_back('{1'b1, 1'b0, 32'h0000_FFFF,  32'h0000_8001,  32'h8000_7FFF,   1'b1, 35});
        vt.push_back('{1'b1, 1'b0, 32'h0001_0000,  32'hFFFF_8000,  32'h8000_0000,   1'b0, 35});
        vt.push_back('{1'b1, 1'b1, 32'd6,          32'd7,          32'd42,          1'b0, 35});

        reset             = 1'b1;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset result", bus.data_result, 32'd0);
        chk("reset exception", {31'd0, bus.data_exception}, 32'd0);
        chk("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i].cm, vt[i].cd, vt[i].a, vt[i].b, vt[i].r, vt[i].e, vt[i].lat,
                   $sformatf("vec%0d", i));
        end

        // MULT aborted by a DIV sampled 10 cycles later: one RDY, 35 cycles after the DIV
        @(negedge clock);
        bus.data_operandA = 32'd6;
        bus.data_operandB = 32'd7;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        n_rdy   = 0;
        first_e = -1;
        r1      = '0;
        for (int e = 1; e <= 80; e++) begin
            if (e == 10) begin
                bus.data_operandA = 32'd50;
                bus.data_operandB = 32'd5;
                bus.ctrl_DIV      = 1'b1;
            end
            @(posedge clock);
            #1;
            bus.ctrl_DIV = 1'b0;
            if (bus.data_resultRDY) begin
                n_rdy++;
                if (n_rdy == 1) begin
                    first_e = e;
                    r1      = bus.data_result;
                end
            end
        end
        chk("abort rdy_count", 32'(n_rdy), 32'd1);
        chk("abort rdy_edge", 32'(first_e), 32'd44);
        chk("abort result", r1, 32'd10);

        // Restart requested in the DONE cycle: both RDY pulses must appear
        @(negedge clock);
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd4;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        n_rdy    = 0;
        first_e  = -1;
        second_e = -1;
        r1       = '0;
        r2       = '0;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clock);
            #1;
            bus.ctrl_DIV = 1'b0;
            if (bus.data_resultRDY) begin
                n_rdy++;
                if (n_rdy == 1) begin
                    first_e           = e;
                    r1                = bus.data_result;
                    bus.data_operandA = 32'd20;
                    bus.data_operandB = 32'd4;
                    bus.ctrl_DIV      = 1'b1;
                end else if (n_rdy == 2) begin
                    second_e = e;
                    r2       = bus.data_result;
                end
            end
        end
        chk("done_restart rdy_count", 32'(n_rdy), 32'd2);
        chk("done_restart first_edge", 32'(first_e), 32'd34);
        chk("done_restart first_result", r1, 32'd12);
        chk("done_restart second_edge", 32'(second_e), 32'd69);
        chk("done_restart second_result", r2, 32'd5);

        // Reset in the middle of a MULT: outputs cleared next cycle and no RDY afterwards
        @(negedge clock);
        bus.data_operandA = 32'd6;
        bus.data_operandB = 32'd7;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        n_rdy = 0;
        for (int e = 1; e <= 60; e++) begin
            if (e == 20) reset = 1'b1;
            if (e == 21) reset = 1'b0;
            @(posedge clock);
            #1;
            if (e == 20) begin
                chk("midreset result", bus.data_result, 32'd0);
                chk("midreset exception", {31'd0, bus.data_exception}, 32'd0);
                chk("midreset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
            end
            if (bus.data_resultRDY) n_rdy++;
        end
        chk("midreset rdy_count", 32'(n_rdy), 32'd0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 1200; i++) begin
            case ($urandom_range(0, 7))
                0: begin
                    ra = 32'($urandom_range(0, 300));
                    rb = 32'($urandom_range(0, 300));
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                1: begin
                    ra = $urandom();
                    rb = 32'd0;
                end
                2: begin
                    ra = corner[$urandom_range(0, 7)];
                    rb = corner[$urandom_range(0, 7)];
                end
                3: begin
                    ra = 32'($signed(16'($urandom())));
                    rb = 32'($signed(16'($urandom())));
                end
                default: begin
                    ra = $urandom();
                    rb = $urandom() >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
            endcase
            rm    = ($urandom_range(0, 1) == 1);
            rboth = ($urandom_range(0, 15) == 0);
            ref_model(ra, rb, rm | rboth, rr, re, rl);
            run_op(rm | rboth, !rm | rboth, ra, rb, rr, re, rl, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
